// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one request at a time to a
// variable-latency instruction memory and fills the IF/ID register.
// A two-entry path (IF/ID plus a one-word skid) absorbs a response that
// arrives while decode is stalled; flushes discard any in-flight response.
module pipe_fetch_stage (
  input  logic        iClk,
  input  logic        iRst_n,
  output logic [31:0] oRdInstAddr,
  output logic        oInstReq,
  input  logic        iInstValid,
  input  logic [31:0] iRdInst,
  input  logic        iStall,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectAddr,
  input  logic        _iPCLoad,
  input  logic [31:0] _iPCLoadData,
  output logic [31:0] oIFID_Inst,
  output logic [31:0] oIFID_PCAddFour,
  output logic        oIFID_Valid,
  output logic [31:0] _oPC
);

  localparam logic [31:0] RESET_VECTOR = 32'h004000a8;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] req_addr_reg;
  logic [31:0] skid_inst_reg;
  logic [31:0] skid_addr_reg;
  logic [31:0] ifid_inst_reg;
  logic [31:0] ifid_pc4_reg;
  logic        ifid_valid_reg;

  logic        flush;
  logic [31:0] target;
  logic        accept;

  // Debug PC load outranks a pipeline redirect; IF/ID can take a new word
  // whenever decode is not stalled or the register holds only a bubble.
  always_comb begin
    flush  = _iPCLoad | iRedirect;
    target = _iPCLoad ? _iPCLoadData : iRedirectAddr;
    accept = ~iStall | ~ifid_valid_reg;
  end

  // Request strobe is combinational so a flush suppresses it in the same
  // cycle; it is gated by reset so nothing is issued while held in reset.
  always_comb begin
    oInstReq    = iRst_n & (state_reg == S_REQ) & ~flush;
    oRdInstAddr = pc_reg;
  end

  assign oIFID_Inst      = ifid_inst_reg;
  assign oIFID_PCAddFour = ifid_pc4_reg;
  assign oIFID_Valid     = ifid_valid_reg;
  assign _oPC            = pc_reg;

  // Fetch FSM, PC, skid buffer and IF/ID register update.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_reg      <= S_REQ;
      pc_reg         <= RESET_VECTOR;
      req_addr_reg   <= 32'h0;
      skid_inst_reg  <= 32'h0;
      skid_addr_reg  <= 32'h0;
      ifid_inst_reg  <= 32'h0;
      ifid_pc4_reg   <= 32'h0;
      ifid_valid_reg <= 1'b0;
    end else if (flush) begin
      // Flush wins over stall: the IF/ID content belongs to the wrong path.
      pc_reg         <= target;
      ifid_inst_reg  <= 32'h0;
      ifid_valid_reg <= 1'b0;
      skid_inst_reg  <= 32'h0;
      skid_addr_reg  <= 32'h0;
      case (state_reg)
        // A request is still in flight unless its response lands now;
        // its data must be swallowed before the new target is fetched.
        S_WAIT, S_DROP: state_reg <= iInstValid ? S_REQ : S_DROP;
        default:        state_reg <= S_REQ;
      endcase
    end else begin
      // Without new data, a stalled IF/ID holds and a free one drains.
      if (!iStall) begin
        ifid_inst_reg  <= 32'h0;
        ifid_valid_reg <= 1'b0;
      end
      case (state_reg)
        S_REQ: begin
          req_addr_reg <= pc_reg;
          pc_reg       <= pc_reg + 32'd4;
          state_reg    <= S_WAIT;
        end
        S_WAIT: begin
          if (iInstValid) begin
            if (accept) begin
              ifid_inst_reg  <= iRdInst;
              ifid_pc4_reg   <= req_addr_reg + 32'd4;
              ifid_valid_reg <= 1'b1;
              state_reg      <= S_REQ;
            end else begin
              skid_inst_reg <= iRdInst;
              skid_addr_reg <= req_addr_reg;
              state_reg     <= S_HOLD;
            end
          end
        end
        S_DROP: begin
          if (iInstValid) begin
            state_reg <= S_REQ;
          end
        end
        S_HOLD: begin
          if (accept) begin
            ifid_inst_reg  <= skid_inst_reg;
            ifid_pc4_reg   <= skid_addr_reg + 32'd4;
            ifid_valid_reg <= 1'b1;
            state_reg      <= S_REQ;
          end
        end
        default: state_reg <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Bench for pipe_fetch_stage: a behavioural memory with configurable latency,
// directed scenarios and a randomized run, all checked every cycle against a
// transaction-level model (outstanding request, held word, IF/ID contents).
module tb_pipe_fetch_stage;

  logic        iClk;
  logic        iRst_n;
  logic [31:0] oRdInstAddr;
  logic        oInstReq;
  logic        iInstValid;
  logic [31:0] iRdInst;
  logic        iStall;
  logic        iRedirect;
  logic [31:0] iRedirectAddr;
  logic        _iPCLoad;
  logic [31:0] _iPCLoadData;
  logic [31:0] oIFID_Inst;
  logic [31:0] oIFID_PCAddFour;
  logic        oIFID_Valid;
  logic [31:0] _oPC;

  pipe_fetch_stage dut (
    .iClk            (iClk),
    .iRst_n          (iRst_n),
    .oRdInstAddr     (oRdInstAddr),
    .oInstReq        (oInstReq),
    .iInstValid      (iInstValid),
    .iRdInst         (iRdInst),
    .iStall          (iStall),
    .iRedirect       (iRedirect),
    .iRedirectAddr   (iRedirectAddr),
    ._iPCLoad        (_iPCLoad),
    ._iPCLoadData    (_iPCLoadData),
    .oIFID_Inst      (oIFID_Inst),
    .oIFID_PCAddFour (oIFID_PCAddFour),
    .oIFID_Valid     (oIFID_Valid),
    ._oPC            (_oPC)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;

  // Compare one observed value against the expected one.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        force_stale = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h004000a8: return 32'h20080001;
      32'h004000ac: return 32'h20090002;
      default:      return {a[15:0], ~a[31:16]} ^ 32'h3c010000;
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_req_addr, m_inst, m_pc4, m_held_inst, m_held_addr;
  logic        m_valid, m_out, m_killed, m_held;
  logic        last_req;
  logic [31:0] last_req_addr;

  task automatic model_reset();
    m_pc = 32'h004000a8; m_req_addr = 0; m_inst = 0; m_pc4 = 0;
    m_held_inst = 0; m_held_addr = 0;
    m_valid = 0; m_out = 0; m_killed = 0; m_held = 0;
  endtask

  // One clock cycle: called at a falling edge, returns at the next one.
  task automatic step(input logic st, input logic rd, input logic [31:0] ra,
                      input logic pl, input logic [31:0] pd);
    logic flush, acc, exp_req;
    logic [31:0] tgt;
    iInstValid = 1'b0;
    iRdInst    = 32'h0;
    if (force_stale) begin
      iInstValid  = 1'b1;
      iRdInst     = 32'hdeadbeef;
      force_stale = 1'b0;
    end else if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        iInstValid = 1'b1;
        iRdInst    = mem_word(mem_addr);
      end
    end
    iStall = st; iRedirect = rd; iRedirectAddr = ra; _iPCLoad = pl; _iPCLoadData = pd;
    #1;
    flush   = pl | rd;
    tgt     = pl ? pd : ra;
    acc     = !st || !m_valid;
    exp_req = !flush && !m_out && !m_held;
    check_eq("ifid_valid", {31'b0, oIFID_Valid}, {31'b0, m_valid});
    check_eq("ifid_inst", oIFID_Inst, m_inst);
    check_eq("ifid_pc4", oIFID_PCAddFour, m_pc4);
    check_eq("pc", _oPC, m_pc);
    check_eq("inst_req", {31'b0, oInstReq}, {31'b0, exp_req});
    if (exp_req) check_eq("req_addr", oRdInstAddr, m_pc);
    last_req      = oInstReq;
    last_req_addr = oRdInstAddr;
    // model update for the coming rising edge
    if (flush) begin
      m_pc = tgt; m_valid = 0; m_inst = 0; m_held = 0;
      if (m_out && iInstValid) m_out = 0;
      else if (m_out) m_killed = 1;
    end else begin
      if (!st) begin m_valid = 0; m_inst = 0; end
      if (exp_req) begin
        m_req_addr = m_pc; m_pc = m_pc + 4; m_out = 1; m_killed = 0;
      end else if (m_out && iInstValid) begin
        m_out = 0;
        if (!m_killed) begin
          if (acc) begin
            m_inst = iRdInst; m_pc4 = m_req_addr + 4; m_valid = 1;
          end else begin
            m_held = 1; m_held_inst = iRdInst; m_held_addr = m_req_addr;
          end
        end
      end else if (m_held && acc) begin
        m_inst = m_held_inst; m_pc4 = m_held_addr + 4; m_valid = 1; m_held = 0;
      end
    end
    if (oInstReq) begin
      mem_cnt  = $urandom_range(lat_max, lat_min);
      mem_addr = oRdInstAddr;
    end
    @(negedge iClk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Advance until the DUT issues a request (bounded).
  task automatic wait_req();
    int g = 0;
    do begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      g++;
    end while (!last_req && g < 20);
    check_eq("wait_req", {31'b0, last_req}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_req"}, {31'b0, oInstReq}, 32'd0);
    check_eq({tag, "_valid"}, {31'b0, oIFID_Valid}, 32'd0);
    check_eq({tag, "_inst"}, oIFID_Inst, 32'h0);
    check_eq({tag, "_pc4"}, oIFID_PCAddFour, 32'h0);
    check_eq({tag, "_pc"}, _oPC, 32'h004000a8);
  endtask

  initial begin
    iRst_n = 1'b0; iInstValid = 0; iRdInst = 0; iStall = 0;
    iRedirect = 0; iRedirectAddr = 0; _iPCLoad = 0; _iPCLoadData = 0;
    last_req = 0; last_req_addr = 0;
    model_reset();
    repeat (2) @(negedge iClk);
    #1 check_reset_values("reset");
    @(negedge iClk);
    iRst_n = 1'b1;

    // Basic fetch with a 1-cycle memory; a stale strobe in S_REQ is ignored.
    force_stale = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("first_req_addr", last_req_addr, 32'h004000a8);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("first_inst", oIFID_Inst, 32'h20080001);
    check_eq("first_pc4", oIFID_PCAddFour, 32'h004000ac);
    idle(4);

    // Stall while IF/ID valid and a response arrives, then release.
    wait_req();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(3);

    // Redirect in S_WAIT with a 3-cycle memory.
    lat_min = 3; lat_max = 3;
    wait_req();
    step(1'b0, 1'b1, 32'h00400200, 1'b0, 32'h0);
    wait_req();
    check_eq("redirect_req_addr", last_req_addr, 32'h00400200);
    idle(4);

    // Redirect coinciding with a response while stalled.
    lat_min = 1; lat_max = 1;
    wait_req();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h00400400, 1'b0, 32'h0);
    check_eq("flush_over_stall", {31'b0, oIFID_Valid}, 32'd0);
    idle(4);

    // Debug load outranks redirect.
    step(1'b0, 1'b1, 32'h00400300, 1'b1, 32'h00400000);
    check_eq("pcload_priority", _oPC, 32'h00400000);
    idle(4);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hfffffffc, 1'b0, 32'h0);
    wait_req();
    check_eq("wrap_req_addr", last_req_addr, 32'hfffffffc);
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_eq("wrap_pc4", oIFID_PCAddFour, 32'h0);
    wait_req();
    check_eq("wrap_next_req", last_req_addr, 32'h0);
    idle(2);

    // Reset mid-S_WAIT aborts everything immediately.
    lat_min = 4; lat_max = 4;
    wait_req();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    iRst_n = 1'b0;
    #1 check_reset_values("midreset");
    mem_cnt = 0;
    model_reset();
    @(negedge iClk);
    iRst_n = 1'b1;
    force_stale = 1'b1;

    // Randomized run.
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      logic st, rd, pl;
      logic [31:0] ra, pd;
      st = ($urandom_range(2, 0) == 0);
      rd = ($urandom_range(9, 0) == 0);
      pl = ($urandom_range(19, 0) == 0);
      ra = ($urandom_range(7, 0) == 0) ? 32'hfffffff4 : ($urandom & 32'hfffffffc);
      pd = $urandom & 32'hfffffffc;
      step(st, rd, ra, pl, pd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_fetch_stage.md
# pipe_fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It owns the PC, issues one-at-a-time requests to a variable-latency instruction memory, and delivers fetched words into the IF/ID pipeline register consumed by the decode stage (control unit and register-file read). It also handles ID stalls, branch/jump redirects and the debug PC-load path.

## Interface
- No parameters. Reset vector fixed at 32'h004000a8.
- iClk  in  1  clock; all state updates on rising edge.
- iRst_n  in  1  reset, asynchronous, active-low.
- oRdInstAddr  out  32  instruction-memory request address; valid when oInstReq=1.
- oInstReq  out  1  request strobe; one cycle per request; memory always accepts.
- iInstValid  in  1  response strobe; at least 1 cycle after the request; at most one outstanding.
- iRdInst  in  32  instruction word; valid when iInstValid=1.
- iStall  in  1  decode stage holds IF/ID.
- iRedirect  in  1  branch/jump/JR taken; flush and refetch.
- iRedirectAddr  in  32  redirect target.
- _iPCLoad  in  1  debug PC load; same effect as iRedirect, higher priority.
- _iPCLoadData  in  32  debug PC value.
- oIFID_Inst  out  32  IF/ID instruction; 32'h0 (NOP) when invalid.
- oIFID_PCAddFour  out  32  IF/ID fetch address + 4.
- oIFID_Valid  out  1  IF/ID holds a real instruction.
- _oPC  out  32  current PC, i.e. the next address to request.

## Operation
- Registers: PC, ReqAddr (address of outstanding request), skid buffer (inst + addr), IF/ID (inst, PCAddFour, valid), 2-bit state.
- Accept = ~iStall | ~oIFID_Valid.
- Flush = _iPCLoad | iRedirect. Target = _iPCLoadData if _iPCLoad, else iRedirectAddr.
- On Flush, regardless of state:
  - PC <= Target.
  - IF/ID valid <= 0 and inst <= 0. Flush overrides iStall.
  - Skid buffer cleared.
  - oInstReq forced to 0.
- States:
  - S_REQ: if no Flush, drive oInstReq=1 and oRdInstAddr=PC; ReqAddr <= PC; PC <= PC+4 (mod 2^32); go to S_WAIT. An iInstValid seen in S_REQ is ignored.
  - S_WAIT: if iInstValid and no Flush: if Accept, IF/ID <= {iRdInst, ReqAddr+4, 1} and go to S_REQ; otherwise skid <= response and go to S_HOLD. If iInstValid and Flush in the same cycle: drop the data, go to S_REQ. If Flush without iInstValid: go to S_DROP.
  - S_DROP: on iInstValid, discard the data and go to S_REQ. A further Flush only updates PC and stays in S_DROP.
  - S_HOLD: if Accept and no Flush, IF/ID <= skid with valid=1 and go to S_REQ. On Flush, go to S_REQ.
- In any state, when no load or flush occurs: if iStall=1, IF/ID holds; if iStall=0, IF/ID becomes a bubble (valid=0, inst=0).
- PC increments only on request issue. Wrap from 32'hFFFFFFFC to 0.

## Timing
- Reset values (asynchronous):
  - PC = 32'h004000a8, state S_REQ.
  - IF/ID inst = 0, PCAddFour = 0, valid = 0.
  - ReqAddr and skid = 0.
  - oInstReq = 0 while iRst_n=0.
- First request: oInstReq=1 in the first cycle after reset release, with address 32'h004000a8.
- Latency: with 1-cycle memory, the request in cycle N returns in N+1 and IF/ID is valid in N+2. Peak throughput is 1 instruction per 2 cycles.
- oInstReq and oRdInstAddr are combinational from state, PC and Flush. IF/ID outputs are registered.
- Reset asserted mid-operation aborts everything. Any stale response arriving after reset lands in S_REQ and is ignored.
- Flush takes effect on the next edge. The first request to Target is issued in the cycle after a Flush, or after the dropped response when the Flush occurred in S_WAIT or S_DROP.

## Test plan
- Reset then 1-cycle memory returning 0x20080001, 0x20090002: requests at 004000a8 and 004000ac. IF/ID valid with PCAddFour 004000ac then 004000b0. Valid toggles 1,0,1 across cycles.
- Stall: iStall=1 while IF/ID is valid and a response arrives → response goes to S_HOLD, IF/ID unchanged. Release iStall → skid instruction appears next cycle, then the next request goes to PC+4.
- Redirect in S_WAIT to 00400200, response arriving 3 cycles later → data dropped, IF/ID valid=0, next request address 00400200.
- Redirect coinciding with iInstValid, plus iStall=1 → IF/ID cleared despite stall. Next request goes to the redirect target.
- _iPCLoad=1 (data 00400000) together with iRedirect=1 (00400300) → PC=00400000. Reset asserted mid-S_WAIT → outputs return to reset values immediately.
- PC=FFFFFFFC fetch → IF/ID PCAddFour=0, next request address 0.
